// File: rtl/cr_ifu_randclk_pkg.sv
// Shared encodings for the IFU random clock-enable generator: modes, FSM states,
// default LFSR seed and the Galois tap table.
package cr_ifu_randclk_pkg;

  typedef logic [1:0] randclk_mode_t;

  localparam randclk_mode_t ModeOff      = 2'd0;
  localparam randclk_mode_t ModeAlways   = 2'd1;
  localparam randclk_mode_t ModeRandom   = 2'd2;
  localparam randclk_mode_t ModePeriodic = 2'd3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  localparam logic [31:0] DefaultSeed = 32'h0000_ACE1;

  // Right-shifting Galois feedback masks (bit k set for polynomial term x^(k+1)).
  function automatic logic [31:0] lfsr_tap(input int unsigned width);
    logic [31:0] tap;
    case (width)
      8:       tap = 32'h0000_00B8;
      9:       tap = 32'h0000_0110;
      10:      tap = 32'h0000_0240;
      11:      tap = 32'h0000_0500;
      12:      tap = 32'h0000_0829;
      13:      tap = 32'h0000_100D;
      14:      tap = 32'h0000_2015;
      15:      tap = 32'h0000_6000;
      16:      tap = 32'h0000_B400;
      24:      tap = 32'h00E1_0000;
      32:      tap = 32'h8020_0003;
      default: tap = (32'h1 << (width - 1)) | (32'h1 << (width - 2));
    endcase
    return tap;
  endfunction

endpackage

// File: rtl/cr_ifu_randclk_lfsr.sv
// Width-parametrised Galois LFSR with advance enable and synchronous load.
// Load wins over advance; the caller guarantees a non-zero load value.
module cr_ifu_randclk_lfsr #(
  parameter int unsigned       Width = 16,
  parameter logic [Width-1:0]  Tap   = Width'(16'hB400),
  parameter logic [Width-1:0]  Seed  = Width'(16'hACE1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [Width-1:0] seed_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (adv_i) begin
      state_d = {1'b0, state_q[Width-1:1]} ^ (state_q[0] ? Tap : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/cr_ifu_randclk_gen.sv
// Per-channel clock-modulation enable generator (off / always / LFSR-random / periodic).
// Optional RANDCLK_SEED_LOAD_EN adds a runtime LFSR seed-load port pair.
module cr_ifu_randclk_gen
  import cr_ifu_randclk_pkg::*;
#(
  parameter int unsigned        CH_NUM = 6,
  parameter int unsigned        LFSR_W = 16,
  parameter int unsigned        PER_W  = 8,
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic [1:0]        cfg_randclk_mode,
  input  logic [3:0]        cfg_randclk_density,
  input  logic [PER_W-1:0]  cfg_randclk_period,
  input  logic              dbg_randclk_hold,
`ifdef RANDCLK_SEED_LOAD_EN
  input  logic              cfg_seed_vld,
  input  logic [LFSR_W-1:0] cfg_seed,
`endif
  output logic [CH_NUM-1:0] randclk_mod_en,
  output logic [LFSR_W-1:0] randclk_lfsr_state
);

  localparam logic [LFSR_W-1:0] FixSeed = LFSR_W'(DefaultSeed);
  localparam logic [LFSR_W-1:0] RstSeed = (SEED == '0) ? FixSeed : SEED;
  localparam logic [LFSR_W-1:0] Tap     = LFSR_W'(lfsr_tap(LFSR_W));

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q;
  logic [PER_W-1:0]  cnt_q, cnt_d;
  logic [CH_NUM-1:0] mod_en_q, mod_en_d;
  logic [CH_NUM-1:0] en_rand;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_adv;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;
  logic              per_hit;
  logic              go_idle;

`ifdef RANDCLK_SEED_LOAD_EN
  assign lfsr_load = cfg_seed_vld;
  assign lfsr_seed = (cfg_seed == '0) ? FixSeed : cfg_seed;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = '0;
`endif

  cr_ifu_randclk_lfsr #(
    .Width (LFSR_W),
    .Tap   (Tap),
    .Seed  (RstSeed)
  ) u_lfsr (
    .clk_i   (forever_cpuclk),
    .rst_ni  (cpurst_b),
    .adv_i   (lfsr_adv),
    .load_i  (lfsr_load),
    .seed_i  (lfsr_seed),
    .state_o (lfsr_q)
  );

  // Channel i compares a 4-bit window of the LFSR starting at bit i (wrapping).
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [3:0] nib;
    assign nib = {lfsr_q[(i + 3) % LFSR_W], lfsr_q[(i + 2) % LFSR_W],
                  lfsr_q[(i + 1) % LFSR_W], lfsr_q[i % LFSR_W]};
    assign en_rand[i] = nib < cfg_randclk_density;
  end

  // >= so that lowering the period below the running count wraps immediately.
  assign per_hit = (cnt_q >= cfg_randclk_period);
  assign go_idle = (cfg_randclk_mode == ModeOff) || dbg_randclk_hold;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mod_en_d = '0;
    lfsr_adv = 1'b0;
    case (state_q)
      StIdle: begin
        if (!go_idle) begin
          state_d = StRun;
        end
      end
      StRun: begin
        lfsr_adv = !dbg_randclk_hold;
        if (!dbg_randclk_hold) begin
          case (mode_q)
            ModeAlways: mod_en_d = '1;
            ModeRandom: mod_en_d = en_rand;
            ModePeriodic: begin
              mod_en_d = {CH_NUM{per_hit}};
              cnt_d    = per_hit ? '0 : cnt_q + PER_W'(1);
            end
            default: mod_en_d = '0;
          endcase
        end
        if (go_idle) begin
          state_d = StIdle;
        end else if (cfg_randclk_mode != mode_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        lfsr_adv = !dbg_randclk_hold;
        cnt_d    = '0;
        state_d  = go_idle ? StIdle : StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= StIdle;
      mode_q   <= ModeOff;
      cnt_q    <= '0;
      mod_en_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= cfg_randclk_mode;
      cnt_q    <= cnt_d;
      mod_en_q <= mod_en_d;
    end
  end

  assign randclk_mod_en     = mod_en_q;
  assign randclk_lfsr_state = lfsr_q;

endmodule

// File: tb/tb_cr_ifu_randclk_gen.sv
// Self-checking bench for cr_ifu_randclk_gen (default parameters).
// Define RANDCLK_SEED_LOAD_EN to also exercise the seed-load port pair.
module tb_cr_ifu_randclk_gen;

  localparam logic [1:0] M_OFF = 2'd0;
  localparam logic [1:0] M_ALW = 2'd1;
  localparam logic [1:0] M_RND = 2'd2;
  localparam logic [1:0] M_PER = 2'd3;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_FLSH = 2;
  // Polynomial x^16+x^14+x^13+x^11+1 as a right-shift Galois feedback mask.
  localparam logic [15:0] TAPS = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  mode;
  logic [3:0]  dens;
  logic [7:0]  per;
  logic        hold;
  logic [5:0]  mod_en;
  logic [15:0] lfsr_state;
`ifdef RANDCLK_SEED_LOAD_EN
  logic        seed_vld;
  logic [15:0] seed;
`endif

  always #5 clk = ~clk;

  cr_ifu_randclk_gen dut (
    .forever_cpuclk      (clk),
    .cpurst_b            (rst_b),
    .cfg_randclk_mode    (mode),
    .cfg_randclk_density (dens),
    .cfg_randclk_period  (per),
    .dbg_randclk_hold    (hold),
`ifdef RANDCLK_SEED_LOAD_EN
    .cfg_seed_vld        (seed_vld),
    .cfg_seed            (seed),
`endif
    .randclk_mod_en      (mod_en),
    .randclk_lfsr_state  (lfsr_state)
  );

  typedef struct {
    logic [1:0] mode;
    logic [3:0] dens;
    logic [7:0] per;
    logic       hold;
    int         cycles;
    logic       chk_en;
    logic [5:0] exp_en;
  } vec_t;

  typedef struct {
    logic [5:0]  en;
    logic [15:0] lfsr;
  } exp_t;

  vec_t  vecs[8];
  exp_t  sb_q[$];
  int    n_run = 0;
  int    n_fail = 0;
  logic [5:0]  s_en;
  logic [15:0] s_lfsr;

  int          m_st;
  logic [1:0]  m_mode;
  logic [7:0]  m_cnt;
  logic [15:0] m_lfsr;
  logic [5:0]  m_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [5:0] rand_en(input logic [15:0] l, input logic [3:0] d);
    logic [31:0] dbl;
    logic [3:0]  nib;
    logic [5:0]  r;
    dbl = {l, l};
    for (int i = 0; i < 6; i++) begin
      nib  = 4'(dbl >> i);
      r[i] = nib < d;
    end
    return r;
  endfunction

  task automatic model_step();
    int          st_n;
    logic [7:0]  cnt_n;
    logic [5:0]  en_n;
    logic        adv;
    logic        idle;
    st_n  = m_st;
    cnt_n = m_cnt;
    en_n  = '0;
    adv   = 1'b0;
    idle  = (mode == M_OFF) || hold;
    if (m_st == S_IDLE) begin
      if (!idle) st_n = S_RUN;
    end else if (m_st == S_RUN) begin
      adv = !hold;
      if (!hold) begin
        if (m_mode == M_ALW) en_n = 6'h3F;
        else if (m_mode == M_RND) en_n = rand_en(m_lfsr, dens);
        else if (m_mode == M_PER) begin
          if (m_cnt >= per) begin
            en_n  = 6'h3F;
            cnt_n = 8'd0;
          end else begin
            cnt_n = m_cnt + 8'd1;
          end
        end
      end
      if (idle) st_n = S_IDLE;
      else if (mode != m_mode) st_n = S_FLSH;
    end else begin
      adv   = !hold;
      cnt_n = 8'd0;
      st_n  = idle ? S_IDLE : S_RUN;
    end
`ifdef RANDCLK_SEED_LOAD_EN
    if (seed_vld) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    else
`endif
    if (adv) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 16'h0);
    m_st   = st_n;
    m_mode = mode;
    m_cnt  = cnt_n;
    m_en   = en_n;
    sb_q.push_back('{en: m_en, lfsr: m_lfsr});
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    s_en   = mod_en;
    s_lfsr = lfsr_state;
    e = sb_q.pop_front();
    check("sb_en", 32'(s_en), 32'(e.en));
    check("sb_lfsr", 32'(s_lfsr), 32'(e.lfsr));
  endtask

  task automatic drive(input logic [1:0] mo, input logic [3:0] de, input logic [7:0] pe,
                       input logic ho);
    mode = mo;
    dens = de;
    per  = pe;
    hold = ho;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ch_cnt[6];
    int          zero_seen;
    logic [15:0] frozen;

    vecs[0] = '{M_PER, 4'd0,  8'd0, 1'b0, 6,  1'b1, 6'h3F};
    vecs[1] = '{M_RND, 4'd0,  8'd0, 1'b0, 20, 1'b1, 6'h00};
    vecs[2] = '{M_RND, 4'd15, 8'd0, 1'b1, 12, 1'b1, 6'h00};
    vecs[3] = '{M_ALW, 4'd0,  8'd0, 1'b0, 6,  1'b1, 6'h3F};
    vecs[4] = '{M_OFF, 4'd0,  8'd0, 1'b0, 10, 1'b1, 6'h00};
    vecs[5] = '{M_ALW, 4'd0,  8'd0, 1'b1, 8,  1'b1, 6'h00};
    vecs[6] = '{M_PER, 4'd0,  8'd7, 1'b0, 30, 1'b0, 6'h00};
    vecs[7] = '{M_OFF, 4'd0,  8'd0, 1'b0, 5,  1'b1, 6'h00};

    drive(M_OFF, 4'd0, 8'd0, 1'b0);
`ifdef RANDCLK_SEED_LOAD_EN
    seed_vld = 1'b0;
    seed     = 16'h0;
`endif
    m_st = S_IDLE; m_mode = M_OFF; m_cnt = 8'd0; m_lfsr = 16'hACE1; m_en = 6'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("reset_en", 32'(mod_en), 32'h0);
    check("reset_lfsr", 32'(lfsr_state), 32'hACE1);

    // Idle in OFF: nothing toggles, LFSR frozen at its seed.
    for (int k = 0; k < 100; k++) begin
      tick();
      check("off_en", 32'(s_en), 32'h0);
      check("off_lfsr", 32'(s_lfsr), 32'hACE1);
    end

    // ALWAYS: first cycle is the IDLE->RUN step, LFSR first advances in RUN.
    drive(M_ALW, 4'd0, 8'd0, 1'b0);
    tick();
    check("alw_first", 32'(s_en), 32'h0);
    tick();
    check("alw_second", 32'(s_en), 32'h3F);
    check("alw_lfsr_step", 32'(s_lfsr), 32'hE270);

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].mode, vecs[i].dens, vecs[i].per, vecs[i].hold);
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      if (vecs[i].chk_en) check($sformatf("vec%0d_en", i), 32'(s_en), 32'(vecs[i].exp_en));
    end

    // PERIODIC period=4 entered through a flush: counter starts at 0.
    drive(M_ALW, 4'd0, 8'd0, 1'b0);
    repeat (3) tick();
    drive(M_PER, 4'd0, 8'd4, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 1) check("per4_change", 32'(s_en), 32'h3F);
      else check($sformatf("per4_k%0d", k), 32'(s_en),
                 (k >= 7 && (k - 7) % 5 == 0) ? 32'h3F : 32'h0);
    end
    drive(M_PER, 4'd0, 8'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("per0_en", 32'(s_en), 32'h3F);
    end

    // RANDOM -> PERIODIC(0): exactly one zero flush cycle.
    drive(M_RND, 4'd15, 8'd0, 1'b0);
    repeat (20) tick();
    drive(M_PER, 4'd0, 8'd0, 1'b0);
    tick();
    tick();
    check("switch_flush", 32'(s_en), 32'h0);
    tick();
    check("switch_run1", 32'(s_en), 32'h3F);
    tick();
    check("switch_run2", 32'(s_en), 32'h3F);

    // Period lowered below the running count wraps on the next compare.
    drive(M_RND, 4'd15, 8'd0, 1'b0);
    repeat (10) tick();
    drive(M_PER, 4'd0, 8'd200, 1'b0);
    repeat (50) tick();
    drive(M_PER, 4'd0, 8'd10, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("lower_k%0d", k), 32'(s_en), (k == 1 || k == 12) ? 32'h3F : 32'h0);
    end

    // RANDOM density 8: duty near 50% per channel, LFSR never zero.
    drive(M_RND, 4'd8, 8'd0, 1'b0);
    zero_seen = 0;
    for (int c = 0; c < 6; c++) ch_cnt[c] = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      for (int c = 0; c < 6; c++) ch_cnt[c] += int'(s_en[c]);
      if (s_lfsr == 16'h0) zero_seen++;
    end
    for (int c = 0; c < 6; c++) begin
      n_run++;
      if (ch_cnt[c] < 1844 || ch_cnt[c] > 2252) begin
        n_fail++;
        $display("FAIL duty_ch%0d: got %0d of 4096, expected 1844..2252", c, ch_cnt[c]);
      end
    end
    check("lfsr_nonzero", 32'(zero_seen), 32'h0);

    // Hold: outputs low, LFSR frozen; release costs one extra zero cycle.
    frozen = m_lfsr;
    drive(M_RND, 4'd8, 8'd0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_en", 32'(s_en), 32'h0);
      check("hold_lfsr", 32'(s_lfsr), 32'(frozen));
    end
    drive(M_RND, 4'd8, 8'd0, 1'b0);
    tick();
    check("release_en", 32'(s_en), 32'h0);
    check("release_lfsr", 32'(s_lfsr), 32'(frozen));
    repeat (20) tick();

`ifdef RANDCLK_SEED_LOAD_EN
    seed_vld = 1'b1;
    seed     = 16'h0;
    tick();
    check("seed_zero", 32'(s_lfsr), 32'hACE1);
    seed = 16'h1234;
    tick();
    check("seed_load", 32'(s_lfsr), 32'h1234);
    seed_vld = 1'b0;
    repeat (10) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
